// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with grant hold and optional hold-time limit.
// The most recently served client drops to lowest priority; all outputs come from flops.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic       HOLD_EN = (MAX_HOLD != 0);
  localparam logic [7:0] CNT_SAT = (MAX_HOLD == 0) ? 8'd255 : 8'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic       busy_q, busy_d;

  logic [1:0] owner;
  logic [1:0] nxt_ptr;
  logic [3:0] others;
  logic [2:0] pick_all;
  logic [2:0] pick_oth;
  logic [3:0] all_onehot;
  logic [3:0] oth_onehot;

  // Returns {found, index}; scans start, start+1, ... mod 4, first hit wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic       found;
    logic [1:0] idx;
    logic [1:0] win;
    found = 1'b0;
    win   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  assign owner    = gnt_id_q;
  assign nxt_ptr  = gnt_id_q + 2'd1;
  assign pick_all = rr_pick(req, ptr_q);
  assign pick_oth = rr_pick(others, nxt_ptr);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_decode
      assign others[gi]     = req[gi] && (owner != 2'(gi));
      assign all_onehot[gi] = (pick_all[1:0] == 2'(gi));
      assign oth_onehot[gi] = (pick_oth[1:0] == 2'(gi));
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (pick_all[2]) begin
          state_d  = GRANT;
          gnt_d    = all_onehot;
          gnt_id_d = pick_all[1:0];
          busy_d   = 1'b1;
          cnt_d    = 8'd1;
        end
      end
      GRANT: begin
        if (!req[owner]) begin
          ptr_d = nxt_ptr;
          if (pick_oth[2]) begin
            gnt_d    = oth_onehot;
            gnt_id_d = pick_oth[1:0];
            cnt_d    = 8'd1;
          end else begin
            state_d  = IDLE;
            gnt_d    = 4'b0000;
            gnt_id_d = 2'd0;
            busy_d   = 1'b0;
            cnt_d    = 8'd0;
          end
        end else if (HOLD_EN && (cnt_q == CNT_SAT)) begin
          // A lone owner keeps the grant but still restarts its hold window.
          ptr_d = nxt_ptr;
          cnt_d = 8'd1;
          if (pick_oth[2]) begin
            gnt_d    = oth_onehot;
            gnt_id_d = pick_oth[1:0];
          end
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd0;
      cnt_q    <= 8'd0;
      gnt_q    <= 4'b0000;
      gnt_id_q <= 2'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter with grant hold and an optional hold-time limit. It shares one downstream resource (for example a shared encoder or bus port) between four clients. Request priority rotates so that the most recently served requester becomes lowest priority. The grant is registered, one-hot, and accompanied by an encoded owner index.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one owner keeps the grant while others are waiting. 0 disables the limit. Legal range 0..255.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset, asynchronous, active-high.
- `req`  input  4  level request per client. Bit i belongs to client i.
- `gnt`  output  4  registered one-hot grant. All zero when nobody owns the resource.
- `gnt_id`  output  2  binary index of the current owner. 0 when `busy`=0.
- `busy`  output  1  equals `|gnt`.

## Operation
- Reset values: `gnt`=0000, `gnt_id`=0, `busy`=0, state IDLE, rotation pointer `ptr`=0, hold counter `cnt`=0.
- Rotating search:
  - Scan order is `ptr`, `ptr`+1, `ptr`+2, `ptr`+3, all mod 4.
  - The first set `req` bit in that order wins.
  - There is no fixed-priority fallback.
- State IDLE:
  - If `req`≠0 at a rising edge, the winner is granted at that edge.
  - Move to GRANT and set `cnt`=1.
  - If `req`=0, remain in IDLE.
- State GRANT (owner o):
  - **Release.** `req[o]`=0 at the edge.
    - Set `ptr`=o+1.
    - Re-run the search on the same edge with o masked out.
    - If there is a winner w, grant w directly, set `cnt`=1 and stay in GRANT. There is no idle bubble.
    - Otherwise clear `gnt`, set `gnt_id`=0 and go to IDLE.
  - **Expiry.** `MAX_HOLD`≠0, `cnt`==`MAX_HOLD` and `req[o]`=1.
    - Set `ptr`=o+1.
    - Search with o masked out.
    - If there is a winner, switch the grant to it and set `cnt`=1.
    - If there is no other requester, o keeps the grant, `cnt` restarts at 1, and `ptr` stays at o+1.
  - **Otherwise.** Keep o and increment `cnt`. `cnt` saturates at `MAX_HOLD`, or at 255 when the limit is disabled.
- Changes to non-owner `req` bits never disturb the current grant.
- Requests are levels, not latched. A request raised and dropped while another client owns the resource is lost.
- Outputs at all times:
  - `gnt` has at most one bit set.
  - `gnt_id` matches the set bit.
  - `gnt` is never set for a client whose `req` was 0 at the granting edge.
- Width rules:
  - `ptr` and `gnt_id` are 2 bits and wrap naturally: 3+1 = 0.
  - `cnt` is 8 bits.

## Timing
- Request-to-grant latency is one edge: `req` is sampled at edge k and `gnt` is visible after edge k.
- Release-to-drop latency is one edge: with `req[o]` low at edge k, `gnt[o]` is low after edge k. A next owner, if any, is granted in the same cycle.
- With `MAX_HOLD`=M and a waiting competitor, the owner holds `gnt` for exactly M cycles.
- Reset mid-grant:
  - `gnt` and `busy` go to 0 immediately, asynchronously, and `ptr` returns to 0.
  - The first edge after `rst` falls arbitrates from client 0.
- All outputs are driven from flops. There is no combinational path from `req` to `gnt`.

## Test plan
- **Single request.** After reset, set `req`=0100. Next cycle `gnt`=0100, `gnt_id`=2, `busy`=1. Drop `req` and the cycle after that `gnt`=0000 and `gnt_id`=0.
- **Fairness.** Hold `req`=1111. Each owner drops its own bit for one cycle after holding 2 cycles. Grant order is 0,1,2,3,0, with back-to-back handoffs and no cycle where `busy`=0.
- **Hold limit.** `MAX_HOLD`=8, `req`=1010 held constant. Grant is 0010 for exactly 8 cycles, then 1000 for 8 cycles, then 0010, alternating.
- **Lone requester past the limit.** `MAX_HOLD`=8, `req`=0001 held for 30 cycles. `gnt` stays 0001 throughout with no glitch. Then raise `req[2]`: grant moves to 0100 at the next expiry, within 8 cycles.
- **Reset mid-grant.** While `gnt`=1000, pulse `rst` between edges. `gnt`=0000 before the next edge. With `req`=1001 after reset, the first grant goes to client 0 (`gnt`=0001).
- **Non-owner noise.** While client 1 owns, toggle `req[0]`, `req[2]` and `req[3]` every cycle with `MAX_HOLD`=0. `gnt` stays 0010 until `req[1]` drops.
